// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mc_ctrl_pkg;

  // Sequencer states; values are visible on the State debug port
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_ADDR   = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_WB_ALU = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_TRAP   = 4'd15
  } state_t;

  // Coarse instruction classes; link (jal/jalr) is carried as a separate flag
  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JREG,
    CLS_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_REG = 2'b11;

  localparam logic [1:0] ALUB_BUSB  = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

endpackage

// File: rtl/mc_instr_class.sv
// rtl/mc_instr_class.sv - opcode/funct to instruction class decode
module mc_instr_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       link
);

  // Classify the IR; anything not recognised falls through to illegal
  always_comb begin
    iclass = CLS_ILLEGAL;
    link   = 1'b0;
    if (opcode == OP_RTYPE) begin
      if (funct == FN_JR) begin
        iclass = CLS_JREG;
      end else if (funct == FN_JALR) begin
        iclass = CLS_JREG;
        link   = 1'b1;
      end else begin
        iclass = CLS_RTYPE;
      end
    end else if (opcode[5:3] == 3'b001) begin
      iclass = CLS_ITYPE;
    end else begin
      case (opcode)
        OP_LW, OP_LB, OP_LBU:                          iclass = CLS_LOAD;
        OP_SW, OP_SB:                                  iclass = CLS_STORE;
        OP_BEQ, OP_BNE, OP_REGIMM, OP_BLEZ, OP_BGTZ:   iclass = CLS_BRANCH;
        OP_J:                                          iclass = CLS_JUMP;
        OP_JAL: begin
          iclass = CLS_JUMP;
          link   = 1'b1;
        end
        default:                                       iclass = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS main sequencer with memory-wait timeout
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OprCtr,
  input  logic [5:0] funct,
  input  logic       MemReady,
  input  logic       BrTaken,
  input  logic       Overflow,
  input  logic       OvfEn,
  output logic       PCWr,
  output logic [1:0] PCSrc,
  output logic       IRWr,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       RegWr,
  output logic       MemtoReg,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       OvfExc,
  output logic       BusErr,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              bus_err_q, illegal_q;
  iclass_t           iclass;
  logic              link;
  logic              mem_wait_st, timeout;

  logic       pcwr, irwr, iord, memrd, memwr, regwr, memtoreg, alusrca;
  logic       done, ovfexc;
  logic [1:0] pcsrc, alusrcb, aluop;

  mc_instr_class u_class (
    .opcode (OprCtr),
    .funct  (funct),
    .iclass (iclass),
    .link   (link)
  );

  assign mem_wait_st = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
  assign timeout     = (wait_q == WAIT_W'(MAX_WAIT)) && !MemReady;

  // Next-state and per-state datapath control decode
  always_comb begin
    state_d  = state_q;
    pcwr     = 1'b0;
    pcsrc    = PCSRC_PC4;
    irwr     = 1'b0;
    iord     = 1'b0;
    memrd    = 1'b0;
    memwr    = 1'b0;
    regwr    = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ALUB_BUSB;
    aluop    = ALUOP_ADD;
    done     = 1'b0;
    ovfexc   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memrd   = 1'b1;
        alusrcb = ALUB_FOUR;
        if (MemReady) begin
          irwr    = 1'b1;
          pcwr    = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        alusrcb = ALUB_IMMSH;
        case (iclass)
          CLS_RTYPE, CLS_ITYPE: state_d = ST_EXEC;
          CLS_LOAD, CLS_STORE:  state_d = ST_ADDR;
          CLS_BRANCH:           state_d = ST_BRANCH;
          CLS_JUMP, CLS_JREG:   state_d = ST_JUMP;
          default:              state_d = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        alusrca = 1'b1;
        if (iclass == CLS_ITYPE) begin
          alusrcb = ALUB_IMM;
          aluop   = ALUOP_ITYPE;
        end else begin
          alusrcb = ALUB_BUSB;
          aluop   = ALUOP_RTYPE;
        end
        if (Overflow && OvfEn) begin
          ovfexc  = 1'b1;
          done    = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB_ALU;
        end
      end
      ST_WB_ALU: begin
        regwr   = 1'b1;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADDR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        state_d = (iclass == CLS_STORE) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        memrd = 1'b1;
        iord  = 1'b1;
        if (MemReady)     state_d = ST_WB_MEM;
        else if (timeout) state_d = ST_TRAP;
      end
      ST_WB_MEM: begin
        regwr    = 1'b1;
        memtoreg = 1'b1;
        done     = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEMWR: begin
        memwr = 1'b1;
        iord  = 1'b1;
        if (MemReady) begin
          done    = 1'b1;
          state_d = ST_FETCH;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_BR;
        pcsrc   = PCSRC_BR;
        pcwr    = BrTaken;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        pcwr    = 1'b1;
        pcsrc   = (iclass == CLS_JREG) ? PCSRC_REG : PCSRC_JMP;
        regwr   = link;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Consecutive memory-wait counter, restarted whenever the state changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wait_q <= '0;
    else if (state_d != state_q)         wait_q <= '0;
    else if (mem_wait_st && !MemReady)   wait_q <= wait_q + WAIT_W'(1);
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (mem_wait_st && timeout)                          bus_err_q <= 1'b1;
      if (state_q == ST_DECODE && state_d == ST_TRAP)      illegal_q <= 1'b1;
    end
  end

  // Strobes are forced low while reset is held so FETCH's read request cannot leak out
  assign PCWr      = rst_n & pcwr;
  assign PCSrc     = rst_n ? pcsrc : 2'b00;
  assign IRWr      = rst_n & irwr;
  assign IorD      = rst_n & iord;
  assign MemRd     = rst_n & memrd;
  assign MemWr     = rst_n & memwr;
  assign RegWr     = rst_n & regwr;
  assign MemtoReg  = rst_n & memtoreg;
  assign ALUsrcA   = rst_n & alusrca;
  assign ALUsrcB   = rst_n ? alusrcb : 2'b00;
  assign ALUOp     = rst_n ? aluop : 2'b00;
  assign InstrDone = rst_n & done;
  assign OvfExc    = rst_n & ovfexc;
  assign BusErr    = bus_err_q;
  assign Illegal   = illegal_q;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for the multi-cycle control sequencer
module tb_mc_control_fsm;

  logic       clk, rst_n;
  logic [5:0] OprCtr, funct;
  logic       MemReady, BrTaken, Overflow, OvfEn;
  logic       PCWr, IRWr, IorD, MemRd, MemWr, RegWr, MemtoReg, ALUsrcA;
  logic [1:0] PCSrc, ALUsrcB, ALUOp;
  logic       InstrDone, OvfExc, BusErr, Illegal;
  logic [3:0] State;

  mc_control_fsm #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .OprCtr(OprCtr), .funct(funct),
    .MemReady(MemReady), .BrTaken(BrTaken), .Overflow(Overflow), .OvfEn(OvfEn),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .IorD(IorD), .MemRd(MemRd),
    .MemWr(MemWr), .RegWr(RegWr), .MemtoReg(MemtoReg), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ALUOp(ALUOp), .InstrDone(InstrDone), .OvfExc(OvfExc),
    .BusErr(BusErr), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation word: {State, PCSrc, ALUOp, ALUsrcB, flags[11:0]}
  // flags = {ALUsrcA, PCWr, IRWr, IorD, MemRd, MemWr, RegWr, MemtoReg, InstrDone, OvfExc, BusErr, Illegal}
  localparam logic [11:0] SA  = 12'h800, PCW = 12'h400, IRW = 12'h200, IOD = 12'h100;
  localparam logic [11:0] MR  = 12'h080, MW  = 12'h040, RW  = 12'h020, M2R = 12'h010;
  localparam logic [11:0] DN  = 12'h008, OVX = 12'h004, BER = 12'h002, ILL = 12'h001;

  localparam logic [21:0] RST      = 22'h0;
  localparam logic [21:0] F_WAIT   = {4'd0,  2'd0, 2'd0, 2'd1, MR};
  localparam logic [21:0] F_HIT    = {4'd0,  2'd0, 2'd0, 2'd1, MR | IRW | PCW};
  localparam logic [21:0] DEC      = {4'd1,  2'd0, 2'd0, 2'd3, 12'h000};
  localparam logic [21:0] EX_R     = {4'd2,  2'd0, 2'd2, 2'd0, SA};
  localparam logic [21:0] EX_I     = {4'd2,  2'd0, 2'd3, 2'd2, SA};
  localparam logic [21:0] EX_I_OVF = {4'd2,  2'd0, 2'd3, 2'd2, SA | OVX | DN};
  localparam logic [21:0] WBA      = {4'd6,  2'd0, 2'd0, 2'd0, RW | DN};
  localparam logic [21:0] ADR      = {4'd3,  2'd0, 2'd0, 2'd2, SA};
  localparam logic [21:0] MRD      = {4'd4,  2'd0, 2'd0, 2'd0, MR | IOD};
  localparam logic [21:0] WBM      = {4'd7,  2'd0, 2'd0, 2'd0, RW | M2R | DN};
  localparam logic [21:0] MWR_HIT  = {4'd5,  2'd0, 2'd0, 2'd0, MW | IOD | DN};
  localparam logic [21:0] BR_T     = {4'd8,  2'd1, 2'd1, 2'd0, SA | PCW | DN};
  localparam logic [21:0] BR_N     = {4'd8,  2'd1, 2'd1, 2'd0, SA | DN};
  localparam logic [21:0] J_J      = {4'd9,  2'd2, 2'd0, 2'd0, PCW | DN};
  localparam logic [21:0] J_JAL    = {4'd9,  2'd2, 2'd0, 2'd0, PCW | RW | DN};
  localparam logic [21:0] J_JR     = {4'd9,  2'd3, 2'd0, 2'd0, PCW | DN};
  localparam logic [21:0] TRAP_BE  = {4'd15, 2'd0, 2'd0, 2'd0, BER};
  localparam logic [21:0] TRAP_IL  = {4'd15, 2'd0, 2'd0, 2'd0, ILL};

  logic [21:0] exp_q[$];
  int          id_q[$];
  int          vec_id = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [5:0]  nxt_op = 6'b0, nxt_fn = 6'b0;
  logic [21:0] obs, want;
  int          want_id;

  // One clock of stimulus: apply inputs, push what the DUT must show this cycle
  task automatic cyc(input logic mr, input logic br, input logic ov, input logic oe,
                     input logic [21:0] e);
    @(posedge clk); #1;
    rst_n = 1'b1; OprCtr = nxt_op; funct = nxt_fn;
    MemReady = mr; BrTaken = br; Overflow = ov; OvfEn = oe;
    exp_q.push_back(e); id_q.push_back(vec_id); vec_id++;
  endtask

  task automatic rst_cyc();
    @(posedge clk); #1;
    rst_n = 1'b0; MemReady = 1'b0; BrTaken = 1'b0; Overflow = 1'b0; OvfEn = 1'b0;
    exp_q.push_back(RST); id_q.push_back(vec_id); vec_id++;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want    = exp_q.pop_front();
      want_id = id_q.pop_front();
      obs = {State, PCSrc, ALUOp, ALUsrcB, ALUsrcA, PCWr, IRWr, IorD, MemRd, MemWr,
             RegWr, MemtoReg, InstrDone, OvfExc, BusErr, Illegal};
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL vec%0d ctrl_word: got %h want %h", want_id, obs, want);
      end
    end
  end

  initial begin
    rst_n = 1'b0; OprCtr = 6'b0; funct = 6'b0;
    MemReady = 1'b0; BrTaken = 1'b0; Overflow = 1'b0; OvfEn = 1'b0;

    rst_cyc(); rst_cyc();

    // add, zero-wait memory
    nxt_op = 6'b000000; nxt_fn = 6'b100000;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,EX_R); cyc(1,0,0,0,WBA);

    // lw with three wait cycles in MEMRD
    nxt_op = 6'b100011; nxt_fn = 6'b000000;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,ADR);
    cyc(0,0,0,0,MRD); cyc(0,0,0,0,MRD); cyc(0,0,0,0,MRD); cyc(1,0,0,0,MRD);
    cyc(1,0,0,0,WBM);

    // sw
    nxt_op = 6'b101011;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,ADR); cyc(1,0,0,0,MWR_HIT);

    // beq taken, then not taken
    nxt_op = 6'b000100;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,1,0,0,BR_T);
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,BR_N);

    // jal and jr
    nxt_op = 6'b000011;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,J_JAL);
    nxt_op = 6'b000000; nxt_fn = 6'b001000;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,J_JR);

    // addi overflowing with check enabled, then with check disabled
    nxt_op = 6'b001000; nxt_fn = 6'b000000;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,1,1,EX_I_OVF);
    cyc(0,0,0,0,F_WAIT); cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC);
    cyc(1,0,1,0,EX_I); cyc(1,0,0,0,WBA);

    // j fetched on the last tolerated wait cycle: no bus error
    nxt_op = 6'b000010;
    for (int i = 0; i < 15; i++) cyc(0,0,0,0,F_WAIT);
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,J_J);

    // reset in the middle of a load, then fetch timeout
    nxt_op = 6'b100011;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,ADR);
    cyc(0,0,0,0,MRD); cyc(0,0,0,0,MRD);
    rst_cyc();
    for (int i = 0; i < 16; i++) cyc(0,0,0,0,F_WAIT);
    cyc(0,0,0,0,TRAP_BE); cyc(1,0,0,0,TRAP_BE); cyc(1,0,0,0,TRAP_BE);

    // illegal opcode after reset clears the bus error
    rst_cyc();
    nxt_op = 6'b111111;
    cyc(1,0,0,0,F_HIT); cyc(1,0,0,0,DEC); cyc(1,0,0,0,TRAP_IL); cyc(1,0,0,0,TRAP_IL);
    rst_cyc();
    cyc(0,0,0,0,F_WAIT);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
